sram22_64x32_port_arbiter: RTL and testbench

Two-requester controller for the 64-word × 32-bit single-port SRAM22 macro (`sramgen_sram_64x32m4w32_replica_v1`). It owns every macro input and shares the one access per cycle between requesters A and B with round-robin arbitration. It routes registered read data back to the requester that issued the read. After reset it optionally zero-fills the array, because the silicon macro powers up with undefined contents.

---
 rtl/sram22_ctrl_pkg.sv | 17 +
 rtl/sram22_rr_arb2.sv | 36 +++
 rtl/sram22_64x32_port_arbiter.sv | 131 +++++++++++++
 tb/tb_sram22_64x32_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram22_ctrl_pkg.sv
// Shared types and constants for the SRAM22 64x32 port arbiter.
// Port and FSM encodings are shared by the arbiter, the top and the bench.
package sram22_ctrl_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int SRAM_DEPTH = 64;

endpackage

// File: rtl/sram22_rr_arb2.sv
// Two-input round-robin arbiter with a one-hot grant (bit 0 = A, bit 1 = B).
// The prio pointer moves to the losing side after every grant and holds otherwise.
module sram22_rr_arb2
    import sram22_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       a_valid,
    input  logic       b_valid,
    output logic [1:0] grant,
    output port_e      prio
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (a_valid && b_valid) begin
                grant = (prio == PORT_A) ? 2'b01 : 2'b10;
            end else begin
                grant = {b_valid, a_valid};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= PORT_A;
        end else if (grant[0]) begin
            prio <= PORT_B;
        end else if (grant[1]) begin
            prio <= PORT_A;
        end
    end

endmodule

// File: rtl/sram22_64x32_port_arbiter.sv
// Two-requester controller for the single-port SRAM22 64x32 macro: zero-fill
// after reset, round-robin sharing of the one access per cycle, read routing.
module sram22_64x32_port_arbiter
    import sram22_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  init_done,
    output logic                  sram_we,
    output logic                  sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic                  DO_CLEAR  = (CLEAR_ON_RESET != 0);

    state_e                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [1:0]              grant;
    port_e                   prio;
    logic                    s1_valid;
    port_e                   s1_port;
    logic                    grant_read;

    sram22_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .enable  (state == RUN),
        .a_valid (a_req_valid),
        .b_valid (b_req_valid),
        .grant   (grant),
        .prio    (prio)
    );

    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];
    assign grant_read  = (grant[0] && !a_req_we) || (grant[1] && !b_req_we);

    // Without zero-fill CLEAR is left on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= (state == RUN);
            case (state)
                CLEAR: begin
                    if (!DO_CLEAR || clr_addr == LAST_ADDR) begin
                        state <= RUN;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                RUN: state <= RUN;
                default: state <= CLEAR;
            endcase
        end
    end

    // Macro drive; idle cycles issue a harmless read of address 0.
    always_comb begin
        sram_we    = 1'b0;
        sram_wmask = 1'b0;
        sram_addr  = '0;
        sram_din   = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                if (DO_CLEAR) begin
                    sram_we    = 1'b1;
                    sram_wmask = 1'b1;
                    sram_addr  = clr_addr;
                end
            end else if (grant[0]) begin
                sram_we    = a_req_we;
                sram_wmask = a_req_we;
                sram_addr  = a_req_addr;
                sram_din   = a_req_wdata;
            end else if (grant[1]) begin
                sram_we    = b_req_we;
                sram_wmask = b_req_we;
                sram_addr  = b_req_addr;
                sram_din   = b_req_wdata;
            end
        end
    end

    // Only reads enter stage 1, so write-cycle macro output is never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_port     <= PORT_A;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_rdata <= '0;
            b_rsp_rdata <= '0;
        end else begin
            s1_valid    <= grant_read;
            s1_port     <= grant[1] ? PORT_B : PORT_A;
            a_rsp_valid <= s1_valid && (s1_port == PORT_A);
            b_rsp_valid <= s1_valid && (s1_port == PORT_B);
            if (s1_valid && s1_port == PORT_A) begin
                a_rsp_rdata <= sram_dout;
            end
            if (s1_valid && s1_port == PORT_B) begin
                b_rsp_rdata <= sram_dout;
            end
        end
    end

endmodule

// File: tb/tb_sram22_64x32_port_arbiter.sv
// Directed bench for sram22_64x32_port_arbiter with a behavioural macro model
// and per-port expected-response queues.
module tb_sram22_64x32_port_arbiter;
    import sram22_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [5:0]  a_req_addr = '0;
    logic [31:0] a_req_wdata = '0;
    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [5:0]  b_req_addr = '0;
    logic [31:0] b_req_wdata = '0;
    logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, init_done;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic        sram_we, sram_wmask;
    logic [5:0]  sram_addr;
    logic [31:0] sram_din, sram_dout;

    logic [31:0] mem [SRAM_DEPTH];
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    int checks = 0;
    int errors = 0;
    int a_rsp_cnt = 0;
    int b_rsp_cnt = 0;

    sram22_64x32_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_rdata (a_rsp_rdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_rdata (b_rsp_rdata),
        .init_done   (init_done),
        .sram_we     (sram_we),
        .sram_wmask  (sram_wmask),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_dout   (sram_dout)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Macro model: registered read; a write cycle outputs a poison word.
    initial begin
        for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = $urandom_range(32'h7fffffff, 1);
        sram_dout = 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (sram_we) begin
            mem[sram_addr] <= sram_din;
            sram_dout      <= 32'hDEADBEEF;
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response must match the head of its port's queue.
    always @(negedge clk) begin
        if (!rst && a_rsp_valid) begin
            a_rsp_cnt++;
            if (exp_a_q.size() == 0) check("a_rsp_spurious", 32'd1, 32'd0);
            else check("a_rsp_data", a_rsp_rdata, exp_a_q.pop_front());
        end
        if (!rst && b_rsp_valid) begin
            b_rsp_cnt++;
            if (exp_b_q.size() == 0) check("b_rsp_spurious", 32'd1, 32'd0);
            else check("b_rsp_data", b_rsp_rdata, exp_b_q.pop_front());
        end
    end

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic we, input logic [5:0] addr, input logic [31:0] wd);
        a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [5:0] addr, input logic [31:0] wd);
        b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
    endtask

    task automatic check_reset_values();
        check("rst_a_ready", a_req_ready, 0);
        check("rst_b_ready", b_req_ready, 0);
        check("rst_a_rsp_valid", a_rsp_valid, 0);
        check("rst_b_rsp_valid", b_rsp_valid, 0);
        check("rst_a_rdata", a_rsp_rdata, 0);
        check("rst_b_rdata", b_rsp_rdata, 0);
        check("rst_init_done", init_done, 0);
        check("rst_sram_we", sram_we, 0);
    endtask

    // Checks n fill cycles from the current one; full also checks the hand-over to RUN.
    task automatic clear_check(input int n, input bit full);
        for (int k = 0; k < n; k++) begin
            check("clr_we", sram_we, 1);
            check("clr_wmask", sram_wmask, 1);
            check("clr_addr", sram_addr, k);
            check("clr_din", sram_din, 0);
            check("clr_a_ready", a_req_ready, 0);
            check("clr_b_ready", b_req_ready, 0);
            check("clr_init_done", init_done, 0);
            step();
        end
        if (full) begin
            set_a(0, 0, 0, 0);
            set_b(0, 0, 0, 0);
            #1;
            check("run_idle_we", sram_we, 0);
            check("init_done_e64", init_done, 0);
            step();
            check("init_done_e65", init_done, 1);
        end
    endtask

    task automatic a_write(input logic [5:0] addr, input logic [31:0] wd);
        set_a(1, 1, addr, wd);
        #1;
        check("a_wr_ready", a_req_ready, 1);
        step();
        set_a(0, 0, 0, 0);
    endtask

    initial begin
        // Reset and first zero-fill
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        #1;
        clear_check(SRAM_DEPTH, 1);

        // Read of a cleared address: latency 2, data 0
        set_a(1, 0, 6'd17, 0);
        #1;
        check("t1_a_ready", a_req_ready, 1);
        exp_a_q.push_back(32'h0);
        step();
        set_a(0, 0, 0, 0);
        check("t1_rsp_early", a_rsp_valid, 0);
        step();
        check("t1_rsp_valid", a_rsp_valid, 1);
        step();
        check("t1_rsp_pulse", a_rsp_valid, 0);

        // A writes, B reads the same address next cycle
        a_write(6'd5, 32'h12345678);
        set_b(1, 0, 6'd5, 0);
        #1;
        check("t2_b_ready", b_req_ready, 1);
        exp_b_q.push_back(32'h12345678);
        step();
        set_b(0, 0, 0, 0);
        step();
        check("t2_b_rsp_valid", b_rsp_valid, 1);
        check("t2_b_rdata", b_rsp_rdata, 32'h12345678);
        check("t2_a_rsp_valid", a_rsp_valid, 0);
        step();

        // Both hold reads for 6 cycles: A,B,A,B,A,B
        a_rsp_cnt = 0;
        b_rsp_cnt = 0;
        set_a(1, 0, 6'd5, 0);
        set_b(1, 0, 6'd17, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t3_a_ready", a_req_ready, (i % 2) == 0);
            check("t3_b_ready", b_req_ready, (i % 2) == 1);
            if (i % 2 == 0) exp_a_q.push_back(32'h12345678);
            else exp_b_q.push_back(32'h0);
            step();
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        repeat (3) step();
        check("t3_a_count", a_rsp_cnt, 3);
        check("t3_b_count", b_rsp_cnt, 3);

        // Back-to-back reads of 1,2,3
        a_write(6'd1, 32'h11);
        a_write(6'd2, 32'h22);
        a_write(6'd3, 32'h33);
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                set_a(1, 0, 6'(c + 1), 0);
                #1;
                check("t4_a_ready", a_req_ready, 1);
                exp_a_q.push_back(32'h11 * (c + 1));
            end else begin
                set_a(0, 0, 0, 0);
            end
            step();
            if (c >= 1 && c <= 3) check("t4_rsp_valid", a_rsp_valid, 1);
            if (c == 4) check("t4_rsp_end", a_rsp_valid, 0);
        end

        // A writes while B's read of the same word is in flight
        set_b(1, 0, 6'd5, 0);
        #1;
        check("t6_b_ready", b_req_ready, 1);
        exp_b_q.push_back(32'h12345678);
        step();
        set_b(0, 0, 0, 0);
        a_write(6'd5, 32'hA5A5A5A5);
        check("t6_b_rsp_valid", b_rsp_valid, 1);
        check("t6_b_rdata_old", b_rsp_rdata, 32'h12345678);
        step();
        check("t6_b_rdata_hold", b_rsp_rdata, 32'h12345678);
        set_a(1, 0, 6'd5, 0);
        #1;
        exp_a_q.push_back(32'hA5A5A5A5);
        step();
        set_a(0, 0, 0, 0);
        repeat (3) step();
        check("t6_b_rdata_keep", b_rsp_rdata, 32'h12345678);

        // Reset mid-RUN, then again mid-CLEAR at clr_addr 30
        rst = 1'b1;
        #1;
        check_reset_values();
        step();
        rst = 1'b0;
        #1;
        clear_check(30, 0);
        check("mid_clr_addr", sram_addr, 30);
        rst = 1'b1;
        #1;
        check("mid_rst_we", sram_we, 0);
        step();
        rst = 1'b0;
        set_a(1, 1, 6'd9, 32'hFFFFFFFF);
        set_b(1, 1, 6'd9, 32'hFFFFFFFF);
        #1;
        clear_check(SRAM_DEPTH, 1);

        // Zero-fill overwrote earlier data
        set_a(1, 0, 6'd5, 0);
        #1;
        check("t5_a_ready", a_req_ready, 1);
        exp_a_q.push_back(32'h0);
        step();
        set_a(0, 0, 0, 0);
        repeat (3) step();

        check("a_queue_empty", exp_a_q.size(), 0);
        check("b_queue_empty", exp_b_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
